systolic_drain_quant: RTL

- Downstream stage of the systolic MAC array.
- After a tile's accumulation completes, it sweeps the array's `matrix_index` select from 0 to ARRAY_SIZE-1 and samples each ARRAY_SIZE-lane `mul_outcome` vector.
- Each lane is requantized to DATA_WIDTH by rounding arithmetic right shift plus saturation.
- Each packed row is presented to the SRAM write path over a valid/ready handshake.

---
 rtl/systolic_drain_quant_if.sv | 32 +++
 rtl/systolic_drain_quant.sv | 127 ++++++++++++
 2 files changed

// File: rtl/systolic_drain_quant_if.sv
// Row-drain bus between the systolic array, the requantizer and the SRAM write path.
// slave = the drain stage, master = the array plus the SRAM writer.
interface systolic_drain_quant_if #(
   parameter int ARRAY_SIZE  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int ORI_WIDTH   = 21,
   parameter int MATRIX_BITS = 6,
   parameter int SHIFT_BITS  = 5
);
   logic                             start;
   logic [SHIFT_BITS-1:0]            shift_amt;
   logic [MATRIX_BITS-1:0]           matrix_index;
   logic [ARRAY_SIZE*ORI_WIDTH-1:0]  mul_outcome;
   logic                             out_valid;
   logic                             out_ready;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data;
   logic [MATRIX_BITS-1:0]           out_row;
   logic                             busy;
   logic                             done;

   // Handshake: a row moves on a rising edge where out_valid && out_ready; while
   // out_valid is high and out_ready low, out_data and out_row stay frozen.
   modport slave (
      input  start, shift_amt, mul_outcome, out_ready,
      output matrix_index, out_valid, out_data, out_row, busy, done
   );

   modport master (
      output start, shift_amt, mul_outcome, out_ready,
      input  matrix_index, out_valid, out_data, out_row, busy, done
   );
endinterface

// File: rtl/systolic_drain_quant.sv
// Drains a finished systolic tile row by row, requantizing every lane with a
// rounding arithmetic shift and saturation, and streams the rows out over valid/ready.
module systolic_drain_quant #(
   parameter int ARRAY_SIZE   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int CUM_BITS_EXT = 5,
   parameter int ORI_WIDTH    = DATA_WIDTH + DATA_WIDTH + CUM_BITS_EXT,
   parameter int MATRIX_BITS  = 6,
   parameter int SHIFT_BITS   = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   systolic_drain_quant_if.slave    bus,
   output logic [1:0]               state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

   // Wide enough that the rounding constant for any shift never reaches the sign bit.
   localparam int WIDE = ORI_WIDTH + (2 ** SHIFT_BITS);
   localparam int SAT_HI = (2 ** (DATA_WIDTH - 1)) - 1;
   localparam int SAT_LO = -(2 ** (DATA_WIDTH - 1));
   localparam logic [MATRIX_BITS-1:0] LAST_ROW = MATRIX_BITS'(ARRAY_SIZE - 1);

   state_t                           state;
   logic [SHIFT_BITS-1:0]            shift_q;
   logic [MATRIX_BITS-1:0]           matrix_index;
   logic                             out_valid;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data;
   logic [MATRIX_BITS-1:0]           out_row;
   logic                             busy;
   logic                             done;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] quant_row;
   logic                             load;

   function automatic logic [DATA_WIDTH-1:0] quant(
      input logic signed [ORI_WIDTH-1:0] v,
      input logic [SHIFT_BITS-1:0]       s
   );
      logic signed [WIDE-1:0] ext;
      logic signed [WIDE-1:0] rnd;
      logic signed [WIDE-1:0] r;
      ext = WIDE'(v);
      if (s == '0) begin
         r = ext;
      end else begin
         rnd = WIDE'(1) << (s - SHIFT_BITS'(1));
         r = (ext + rnd) >>> s;
      end
      if (r > WIDE'(SAT_HI)) begin
         r = WIDE'(SAT_HI);
      end else if (r < WIDE'(SAT_LO)) begin
         r = WIDE'(SAT_LO);
      end
      return r[DATA_WIDTH-1:0];
   endfunction

   always_comb begin
      quant_row = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         quant_row[i*DATA_WIDTH +: DATA_WIDTH] =
            quant(bus.mul_outcome[i*ORI_WIDTH +: ORI_WIDTH], shift_q);
      end
   end

   assign load = !out_valid || bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         shift_q      <= '0;
         matrix_index <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_row      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shift_q      <= bus.shift_amt;
                  matrix_index <= '0;
                  busy         <= 1'b1;
                  state        <= RUN;
               end
            end
            RUN: begin
               if (load) begin
                  out_data  <= quant_row;
                  out_row   <= matrix_index;
                  out_valid <= 1'b1;
                  // Hold the last index so the array keeps presenting a stable row.
                  if (matrix_index == LAST_ROW) begin
                     state <= DRAIN;
                  end else begin
                     matrix_index <= matrix_index + MATRIX_BITS'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_valid && bus.out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= FIN;
               end
            end
            FIN: begin
               matrix_index <= '0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.matrix_index = matrix_index;
   assign bus.out_valid    = out_valid;
   assign bus.out_data     = out_data;
   assign bus.out_row      = out_row;
   assign bus.busy         = busy;
   assign bus.done         = done;
   assign state_dbg        = state;

endmodule
